approx_mult_accumulator: RTL and testbench
==========================================

// Module: approx_mult_accumulator
// PURPOSE
//   Downstream stage of the 8x8 unsigned approximate multipliers. Takes one
//   16-bit product z per accepted beat and adds a fixed per-product bias to
//   offset the multiplier's mean error. Accumulates the compensated products
//   over a frame delimited by in_last, then presents the frame sum, beat count
//   and overflow flag on a valid/ready output. Used for dot-product style
//   error evaluation of the approximate multiplier family.
// PARAMETERS
//   PROD_W  16  width of incoming product z (matches 8x8 multiplier output)
//   ACC_W   24  accumulator / out_sum width; must be > PROD_W
//   CNT_W   8   beat counter width
//   BIAS    0   unsigned compensation constant added with every accepted product
// PORTS
//   clk        in   1       clock, all state changes on rising edge
//   rst        in   1       asynchronous reset, active-high
//   in_valid   in   1       product beat valid
//   in_ready   out  1       block can accept a beat this cycle
//   in_z       in   PROD_W  product from approximate multiplier
//   in_last    in   1       beat closes current frame (qualified by in_valid)
//   out_valid  out  1       frame result valid
//   out_ready  in   1       consumer accepts result
//   out_sum    out  ACC_W   saturated sum of (in_z + BIAS) over frame
//   out_count  out  CNT_W   beats in frame, saturating at 2^CNT_W-1
//   out_ovf    out  1       sticky: sum saturated at some point in frame
// BEHAVIOUR
//   Reset (async, immediate): state=ACC, acc=0, cnt=0, ovf=0,
//     out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=1 after reset.
//   Beat accepted when in_valid && in_ready.
//   States: ACC (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
//   ACC, accepted beat:
//     - nxt = acc + in_z + BIAS computed at ACC_W+1 bits.
//     - If nxt > 2^ACC_W-1: nxt clamps to 2^ACC_W-1 and ovf is set.
//     - cnt <= cnt+1, saturating at 2^CNT_W-1 (no flag).
//     - in_last=0: acc <= nxt, stay in ACC.
//     - in_last=1: out_sum <= nxt, out_count <= cnt+1 (sat), and
//       out_ovf <= ovf|new_ovf. Then acc, cnt, ovf <= 0 and go to HOLD.
//       out_valid is high the cycle after the last beat, giving one-cycle
//       latency from the last beat to the result.
//   ACC, no accepted beat: all state held.
//   HOLD:
//     - out_sum, out_count and out_ovf are stable while out_valid && !out_ready.
//     - in_ready=0, so no beat is accepted.
//     - On out_valid && out_ready: out_valid <= 0 and go to ACC. in_ready
//       rises the next cycle, so there is a one-cycle bubble per frame.
//   in_ready and out_valid are decoded from registered state only (no
//     combinational in->out paths).
//   in_last with in_valid=0 is ignored. A single-beat frame (first beat has
//     in_last=1) is legal and gives out_count=1.
//   in_z is treated as unsigned. BIAS is zero-extended to ACC_W.
//   Reset asserted mid-frame or in HOLD discards the partial or pending
//     result. No output is produced for that frame.
// TESTING
//   1 BIAS=0: beats 100,200,300(last) -> out_sum=600, out_count=3, out_ovf=0,
//     out_valid high exactly 1 cycle after third beat.
//   2 BIAS=4: beats 10,20(last) -> out_sum=38, out_count=2.
//   3 ACC_W=17: beats 0xFFFF,0xFFFF,0xFFFF(last) -> out_sum=131071, out_ovf=1.
//     Next frame of 5(last) -> out_sum=5, out_ovf=0.
//   4 Backpressure: frame 7(last), hold out_ready=0 for 5 cycles ->
//     out_valid=1, out_sum=7 stable, in_ready=0 throughout. Then out_ready=1
//     for 1 cycle -> out_valid=0 and in_ready=1 on the following cycle.
//   5 Reset mid-frame: beats 50,60, pulse rst, then beat 7(last) ->
//     out_sum=7, out_count=1.
//   6 Single beat 0xFFFF(last), BIAS=0 -> out_sum=65535, out_count=1.
//     Also drive 300 beats of 1 with CNT_W=8 -> out_count=255, out_sum=300.

Source files
------------

// File: rtl/approx_mult_accumulator.sv
// Bias-compensated, saturating frame accumulator for approximate-multiplier
// products. Presents frame sum, beat count and overflow on a valid/ready port.
module approx_mult_accumulator #(
  parameter int          PROD_W = 16,
  parameter int          ACC_W  = 24,
  parameter int          CNT_W  = 8,
  parameter int unsigned BIAS   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_z,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int               SUM_W   = ACC_W + 1;
  localparam logic [SUM_W-1:0] BIAS_X  = SUM_W'(BIAS);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             out_ovf_q;

  logic [SUM_W-1:0] sum_wide;
  logic             sat_ovf;
  logic [ACC_W-1:0] sum_d;
  logic [CNT_W-1:0] cnt_d;
  logic             beat;

  // One extra bit of headroom is enough to detect that the running sum
  // crossed the accumulator range on this beat.
  always_comb begin
    sum_wide = {1'b0, acc_q} + SUM_W'(in_z) + BIAS_X;
    sat_ovf  = (sum_wide > {1'b0, ACC_MAX});
    sum_d    = sat_ovf ? ACC_MAX : sum_wide[ACC_W-1:0];
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    beat     = in_valid && (state_q == S_ACC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (beat) begin
            if (in_last) begin
              sum_q     <= sum_d;
              count_q   <= cnt_d;
              out_ovf_q <= ovf_q | sat_ovf;
              acc_q     <= '0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
              state_q   <= S_HOLD;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_q | sat_ovf;
            end
          end
        end
        S_HOLD: begin
          // Result registers stay frozen until the consumer takes them.
          if (out_ready) begin
            state_q <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_approx_mult_accumulator.sv
// Scoreboard bench: three accumulator instances (BIAS=0, BIAS=4, ACC_W=17)
// driven by directed and random frames, results checked by a monitor.
module tb_approx_mult_accumulator;

  typedef struct {
    int     inst;
    longint sum;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_last = '0;
  logic [2:0]  out_ready = 3'b111;
  logic [15:0] in_z [3];
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  out_ovf;
  wire  [23:0] out_sum [3];
  wire  [7:0]  out_count [3];

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     rand_rdy = 1'b0;
  longint tot [3];
  int     nb [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int          AW = (gi == 2) ? 17 : 24;
      localparam int unsigned BS = (gi == 1) ? 4 : 0;
      logic [AW-1:0] sum_w;
      approx_mult_accumulator #(
        .PROD_W(16), .ACC_W(AW), .CNT_W(8), .BIAS(BS)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_z      (in_z[gi]),
        .in_last   (in_last[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_sum   (sum_w),
        .out_count (out_count[gi]),
        .out_ovf   (out_ovf[gi])
      );
      assign out_sum[gi] = 24'(sum_w);
    end
  endgenerate

  function automatic longint bias_of(input int k);
    return (k == 1) ? 4 : 0;
  endfunction

  function automatic int accw_of(input int k);
    return (k == 2) ? 17 : 24;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: the clamped running sum of non-negative terms equals
  // min(total, max), and overflow occurred iff total exceeded max.
  task automatic beat(input int k, input int z, input bit last);
    int     t;
    longint mx;
    exp_t   e;
    t = 0;
    while (!in_ready[k] && t < 100) begin
      if (rand_rdy) out_ready = 3'($urandom);
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("in_ready_wait_inst%0d", k), longint'(in_ready[k]), 1);
    if (!in_ready[k]) return;
    in_valid[k] = 1'b1;
    in_z[k]     = 16'(z);
    in_last[k]  = last;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
    tot[k] += longint'(z) + bias_of(k);
    nb[k]++;
    if (last) begin
      mx    = (longint'(1) << accw_of(k)) - 1;
      e.inst = k;
      e.sum  = (tot[k] > mx) ? mx : tot[k];
      e.ovf  = (tot[k] > mx);
      e.cnt  = (nb[k] > 255) ? 255 : nb[k];
      sb.push_back(e);
      tot[k] = 0;
      nb[k]  = 0;
      chk($sformatf("latency_out_valid_inst%0d", k), longint'(out_valid[k]), 1);
    end
    if (rand_rdy) out_ready = 3'($urandom);
  endtask

  // Monitor: results of one instance arrive in order; instances may interleave.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && out_valid[k] && out_ready[k]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].inst == k) idx = i;
        n_cmp++;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL unexpected_result inst=%0d sum=%0d count=%0d ovf=%0b required none",
                   k, out_sum[k], out_count[k], out_ovf[k]);
        end else begin
          if (longint'(out_sum[k]) != sb[idx].sum || int'(out_count[k]) != sb[idx].cnt ||
              out_ovf[k] != sb[idx].ovf) begin
            n_bad++;
            $display("FAIL result inst=%0d actual sum=%0d count=%0d ovf=%0b required sum=%0d count=%0d ovf=%0b",
                     k, out_sum[k], out_count[k], out_ovf[k], sb[idx].sum, sb[idx].cnt, sb[idx].ovf);
          end else begin
            $display("result inst=%0d sum=%0d count=%0d ovf=%0b ok", k, out_sum[k], out_count[k], out_ovf[k]);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", longint'(sb.size()), 0);
  endtask

  initial begin
    int k, len, z;
    for (int i = 0; i < 3; i++) begin
      in_z[i] = '0;
      tot[i]  = 0;
      nb[i]   = 0;
    end
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_in_ready_inst%0d", i), longint'(in_ready[i]), 1);
      chk($sformatf("reset_out_valid_inst%0d", i), longint'(out_valid[i]), 0);
    end
    chk("reset_out_sum", longint'(out_sum[0]), 0);
    chk("reset_out_count", longint'(out_count[0]), 0);
    chk("reset_out_ovf", longint'(out_ovf[0]), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic sum, bias, saturation and post-saturation recovery.
    beat(0, 100, 0); beat(0, 200, 0); beat(0, 300, 1);
    beat(1, 10, 0);  beat(1, 20, 1);
    beat(2, 16'hFFFF, 0); beat(2, 16'hFFFF, 0); beat(2, 16'hFFFF, 1);
    beat(2, 5, 1);
    drain();

    // Backpressure on instance 0.
    out_ready[0] = 1'b0;
    beat(0, 7, 1);
    repeat (5) begin
      chk("hold_out_valid", longint'(out_valid[0]), 1);
      chk("hold_out_sum", longint'(out_sum[0]), 7);
      chk("hold_in_ready", longint'(in_ready[0]), 0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", longint'(out_valid[0]), 0);
    chk("release_in_ready", longint'(in_ready[0]), 1);

    // Reset mid-frame discards the partial frame.
    beat(0, 50, 0); beat(0, 60, 0);
    rst = 1'b1;
    #1;
    chk("midreset_in_ready", longint'(in_ready[0]), 1);
    chk("midreset_out_valid", longint'(out_valid[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tot[i] = 0;
      nb[i]  = 0;
    end
    beat(0, 7, 1);

    // Single full-scale beat, then a frame long enough to saturate the count.
    beat(0, 16'hFFFF, 1);
    for (int i = 0; i < 300; i++) beat(0, 1, (i == 299));
    drain();

    // Random frames across instances with random backpressure and gaps.
    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      k   = $urandom_range(0, 2);
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        z = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 65535);
        beat(k, z, (b == len - 1));
        repeat ($urandom_range(0, 2)) begin
          out_ready = 3'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 3'b111;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
